// File: rtl/uart_rx_conditioner.sv
// Board-side UART RX pin conditioner: resynchroniser, glitch filter, fall and line-break reporting.
// Break detector is built only when UART_RX_CONDITIONER_BREAK_EN is defined.
module uart_rx_conditioner #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int BREAK_CYCLES  = 2048
) (
  input  logic clock,
  input  logic reset,
  input  logic uart_rx,
  output logic rx_clean,
  output logic rx_fall,
  output logic break_active,
  output logic break_detected
);

  localparam int FCW = $clog2(FILTER_CYCLES + 1);
  localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_CYCLES - 1);

  generate
    if (SYNC_STAGES < 2 || FILTER_CYCLES < 1 || BREAK_CYCLES <= FILTER_CYCLES) begin : g_param_check
      $error("uart_rx_conditioner: illegal SYNC_STAGES/FILTER_CYCLES/BREAK_CYCLES");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_r;
  logic [FCW-1:0]         filt_cnt_r;
  logic                   samp_s;
  logic                   flip_s;

  // Filter decision: flip once FILTER_CYCLES consecutive samples disagree with rx_clean
  always_comb begin
    samp_s = sync_r[SYNC_STAGES-1];
    flip_s = 1'b0;
    if (samp_s != rx_clean) begin
      flip_s = (filt_cnt_r == FILT_LAST);
    end else begin
      flip_s = 1'b0;
    end
  end

  // Synchroniser chain, preset to the idle level
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], uart_rx};
    end
  end

  // Glitch filter and falling-edge pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      filt_cnt_r <= {FCW{1'b0}};
      rx_clean   <= 1'b1;
      rx_fall    <= 1'b0;
    end else if (samp_s == rx_clean) begin
      filt_cnt_r <= {FCW{1'b0}};
      rx_fall    <= 1'b0;
    end else if (flip_s) begin
      filt_cnt_r <= {FCW{1'b0}};
      rx_clean   <= samp_s;
      rx_fall    <= ~samp_s;
    end else begin
      filt_cnt_r <= filt_cnt_r + FCW'(1);
      rx_fall    <= 1'b0;
    end
  end

`ifdef UART_RX_CONDITIONER_BREAK_EN
  localparam int LCW = $clog2(BREAK_CYCLES + 1);
  localparam logic [LCW-1:0] LOW_MAX = LCW'(BREAK_CYCLES);
  localparam logic [LCW-1:0] LOW_HIT = LCW'(BREAK_CYCLES - 1);

  logic [LCW-1:0] low_cnt_r;
  logic           rise_s;
  logic           hit_s;

  // A low period that ends on this very edge is not reported as a break
  always_comb begin
    rise_s = flip_s & samp_s;
    hit_s  = ~rx_clean & (low_cnt_r == LOW_HIT) & ~rise_s;
  end

  // Low-period counter, saturating so only one break is flagged per low period
  always_ff @(posedge clock) begin
    if (reset) begin
      low_cnt_r      <= {LCW{1'b0}};
      break_active   <= 1'b0;
      break_detected <= 1'b0;
    end else begin
      if (rx_clean) begin
        low_cnt_r <= {LCW{1'b0}};
      end else if (low_cnt_r != LOW_MAX) begin
        low_cnt_r <= low_cnt_r + LCW'(1);
      end else begin
        low_cnt_r <= low_cnt_r;
      end
      break_detected <= hit_s;
      if (rise_s) begin
        break_active <= 1'b0;
      end else if (hit_s) begin
        break_active <= 1'b1;
      end else begin
        break_active <= break_active;
      end
    end
  end
`else
  assign break_active   = 1'b0;
  assign break_detected = 1'b0;
`endif

endmodule
